// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-requester external memory arbiter.
// Consumed by mem_arb_prio and mem_arbiter via import mem_arb_pkg::*.
package mem_arb_pkg;

  localparam int DEF_AW       = 32;
  localparam int DEF_DW       = 32;
  localparam int DEF_MAX_HOLD = 4;
  localparam int DEF_TIMEOUT  = 64;
  localparam int HOLD_W       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_D  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  // The read-wait state already identifies which requester owns the pending read.
  function automatic owner_e state_owner(input arb_state_e s);
    return (s == RD_D) ? OWN_D : OWN_IF;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-over-fetch priority with a starvation guard: after MAX_HOLD
// consecutive data grants while fetch waits, fetch is forced through.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_if_req,
  input  logic i_d_req,
  output logic o_gnt_if,
  output logic o_gnt_d
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              force_if;

  always_comb begin
    force_if = i_if_req && (hold_cnt_q == HOLD_MAX);
    o_gnt_d  = i_active && i_d_req && !force_if;
    o_gnt_if = i_active && i_if_req && !o_gnt_d;

    hold_cnt_d = hold_cnt_q;
    if (!i_if_req || o_gnt_if) begin
      hold_cnt_d = '0;
    end else if (o_gnt_d && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter for a single external memory port, one read outstanding.
// Optional read-wait timeout is enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_rvd,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic [AW-1:0] i_d_addr,
  input  logic [DW-1:0] i_d_wdata,
  output logic          o_d_gnt,
  output logic [DW-1:0] o_d_rdata,
  output logic          o_d_rvd,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic          o_mem_we,
  output logic          o_mem_re,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_rvd,
  output logic          o_busy
`ifdef MEM_ARBITER_TIMEOUT_EN
  ,
  output logic          o_timeout
`endif
);

  arb_state_e    state_q, state_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          active;
  logic          gnt_if, gnt_d;
  logic          deliver;
  logic [DW-1:0] ret_data;
  owner_e        owner;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              tmo;
`endif

  // Reset gates the combinational grant path so no command leaks out during reset.
  assign active = (state_q == IDLE) && !rst;
  assign owner  = state_owner(state_q);

  mem_arb_prio #(
    .MAX_HOLD (MAX_HOLD)
  ) u_prio (
    .clk      (clk),
    .rst      (rst),
    .i_active (active),
    .i_if_req (i_if_req),
    .i_d_req  (i_d_req),
    .o_gnt_if (gnt_if),
    .o_gnt_d  (gnt_d)
  );

  assign o_if_gnt    = gnt_if;
  assign o_d_gnt     = gnt_d;
  assign o_mem_addr  = gnt_if ? i_if_addr : i_d_addr;
  assign o_mem_wdata = i_d_wdata;
  assign o_mem_we    = gnt_d && i_d_we;
  assign o_mem_re    = gnt_if || (gnt_d && !i_d_we);
  assign o_busy      = (state_q != IDLE);

  always_comb begin
    state_d  = state_q;
    deliver  = 1'b0;
    ret_data = i_mem_rdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
    wait_d   = '0;
    tmo      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_if) begin
          state_d = RD_IF;
        end else if (gnt_d && !i_d_we) begin
          state_d = RD_D;
        end
      end
      RD_IF, RD_D: begin
`ifdef MEM_ARBITER_TIMEOUT_EN
        wait_d = wait_q + WAIT_W'(1);
`endif
        if (i_mem_rvd) begin
          deliver = 1'b1;
        end
`ifdef MEM_ARBITER_TIMEOUT_EN
        else if (wait_q == TMO_LAST) begin
          deliver  = 1'b1;
          ret_data = '0;
          tmo      = 1'b1;
        end
`endif
        if (deliver) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Read data is forwarded combinationally on the return cycle, then held.
    o_if_rvd   = deliver && !rst && (owner == OWN_IF);
    o_d_rvd    = deliver && !rst && (owner == OWN_D);
    o_if_rdata = o_if_rvd ? ret_data : if_rdata_q;
    o_d_rdata  = o_d_rvd ? ret_data : d_rdata_q;
    if_rdata_d = o_if_rdata;
    d_rdata_d  = o_d_rdata;
  end

`ifdef MEM_ARBITER_TIMEOUT_EN
  assign o_timeout = tmo && !rst;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wait_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wait_q     <= wait_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MAX_HOLD=4, TIMEOUT=8).
// Timeout scenarios run only when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic          i_if_req;
  logic [AW-1:0] i_if_addr;
  logic          o_if_gnt;
  logic [DW-1:0] o_if_rdata;
  logic          o_if_rvd;
  logic          i_d_req;
  logic          i_d_we;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic          o_d_gnt;
  logic [DW-1:0] o_d_rdata;
  logic          o_d_rvd;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_we;
  logic          o_mem_re;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_rvd;
  logic          o_busy;
`ifdef MEM_ARBITER_TIMEOUT_EN
  logic          o_timeout;
`endif

  int vectors;
  int miscompares;

  mem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_HOLD (4),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_if_req    (i_if_req),
    .i_if_addr   (i_if_addr),
    .o_if_gnt    (o_if_gnt),
    .o_if_rdata  (o_if_rdata),
    .o_if_rvd    (o_if_rvd),
    .i_d_req     (i_d_req),
    .i_d_we      (i_d_we),
    .i_d_addr    (i_d_addr),
    .i_d_wdata   (i_d_wdata),
    .o_d_gnt     (o_d_gnt),
    .o_d_rdata   (o_d_rdata),
    .o_d_rvd     (o_d_rvd),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_re    (o_mem_re),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_rvd   (i_mem_rvd),
    .o_busy      (o_busy)
`ifdef MEM_ARBITER_TIMEOUT_EN
    ,
    .o_timeout   (o_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    vectors++;
    if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re, o_if_rvd, o_d_rvd, o_busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got %b exp 0000000",
               {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re, o_if_rvd, o_d_rvd, o_busy});
    end
    vectors++;
    if ({o_if_rdata, o_d_rdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_rdata got %h/%h exp 0/0", o_if_rdata, o_d_rdata);
    end
    next_cycle();
    rst = 1'b0;
    #1;
    vectors++;
    if ({o_busy, o_mem_we, o_mem_re} !== 3'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle got %b exp 000", {o_busy, o_mem_we, o_mem_re});
    end
    $display("txn reset done");
    next_cycle();
  endtask

  task automatic test_write;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h100; i_d_wdata = 32'hDEADBEEF;
    #1;
    vectors++;
    if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re} !== 4'b0110) begin
      miscompares++;
      $display("FAIL write_strobes got %b exp 0110", {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re});
    end
    vectors++;
    if ({o_mem_addr, o_mem_wdata} !== {32'h100, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL write_addr_data got %h/%h exp 00000100/deadbeef", o_mem_addr, o_mem_wdata);
    end
    $display("txn write addr=%h data=%h", o_mem_addr, o_mem_wdata);
    next_cycle();
    i_d_req = 1'b0; i_d_we = 1'b0;
    // stray return strobe while idle must be ignored
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h12345678;
    #1;
    vectors++;
    if ({o_busy, o_if_rvd, o_d_rvd} !== 3'b000) begin
      miscompares++;
      $display("FAIL write_stays_idle got %b exp 000", {o_busy, o_if_rvd, o_d_rvd});
    end
    next_cycle();
    i_mem_rvd = 1'b0;
  endtask

  task automatic test_fetch_read;
    i_if_req = 1'b1; i_if_addr = 32'h0;
    #1;
    vectors++;
    if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re, o_mem_addr} !== {4'b1001, 32'h0}) begin
      miscompares++;
      $display("FAIL fetch_grant got %b addr %h exp 1001 addr 0",
               {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re}, o_mem_addr);
    end
    next_cycle();
    i_if_req = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      #1;
      vectors++;
      if ({o_busy, o_mem_re, o_if_rvd} !== 3'b100) begin
        miscompares++;
        $display("FAIL fetch_wait_c%0d got %b exp 100", c, {o_busy, o_mem_re, o_if_rvd});
      end
      next_cycle();
    end
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h00000013;
    #1;
    vectors++;
    if ({o_busy, o_if_rvd, o_d_rvd, o_if_rdata} !== {3'b110, 32'h13}) begin
      miscompares++;
      $display("FAIL fetch_return got busy/ifrvd/drvd %b rdata %h exp 110 00000013",
               {o_busy, o_if_rvd, o_d_rvd}, o_if_rdata);
    end
    $display("txn fetch read addr=0 rdata=%h", o_if_rdata);
    next_cycle();
    i_mem_rvd = 1'b0;
    #1;
    vectors++;
    if ({o_busy, o_if_rvd, o_if_rdata} !== {2'b00, 32'h13}) begin
      miscompares++;
      $display("FAIL fetch_hold got busy/rvd %b rdata %h exp 00 00000013",
               {o_busy, o_if_rvd}, o_if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation;
    i_if_req = 1'b1; i_if_addr = 32'h80;
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h300; i_d_wdata = 32'hCAFE0000;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        #1;
        vectors++;
        if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re} !== 4'b0110) begin
          miscompares++;
          $display("FAIL starve_r%0d_data%0d got %b exp 0110", r, k,
                   {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re});
        end
        next_cycle();
      end
      #1;
      vectors++;
      if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re, o_mem_addr} !== {4'b1001, 32'h80}) begin
        miscompares++;
        $display("FAIL starve_r%0d_fetch got %b addr %h exp 1001 addr 00000080", r,
                 {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re}, o_mem_addr);
      end
      next_cycle();
      i_mem_rvd = 1'b1; i_mem_rdata = 32'h1000 + r;
      #1;
      vectors++;
      if ({o_if_gnt, o_d_gnt, o_if_rvd, o_if_rdata} !== {3'b001, 32'h1000 + r}) begin
        miscompares++;
        $display("FAIL starve_r%0d_return got gnts/rvd %b rdata %h exp 001 %h", r,
                 {o_if_gnt, o_d_gnt, o_if_rvd}, o_if_rdata, 32'h1000 + r);
      end
      $display("txn starvation round %0d fetch rdata=%h", r, o_if_rdata);
      next_cycle();
      i_mem_rvd = 1'b0;
    end
    i_if_req = 1'b0; i_d_req = 1'b0; i_d_we = 1'b0;
    next_cycle();
  endtask

  task automatic test_read_blocks_fetch;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h200;
    #1;
    vectors++;
    if ({o_if_gnt, o_d_gnt, o_mem_we, o_mem_re, o_mem_addr} !== {4'b0101, 32'h200}) begin
      miscompares++;
      $display("FAIL dread_grant got %b addr %h exp 0101 addr 00000200",
               {o_if_gnt, o_d_gnt, o_mem_we, o_mem_re}, o_mem_addr);
    end
    next_cycle();
    i_d_req = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h40;
    for (int c = 1; c <= 2; c++) begin
      #1;
      vectors++;
      if ({o_if_gnt, o_mem_re, o_busy} !== 3'b001) begin
        miscompares++;
        $display("FAIL dread_block_c%0d got %b exp 001", c, {o_if_gnt, o_mem_re, o_busy});
      end
      next_cycle();
    end
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h55;
    #1;
    vectors++;
    if ({o_if_gnt, o_d_rvd, o_if_rvd, o_d_rdata} !== {3'b010, 32'h55}) begin
      miscompares++;
      $display("FAIL dread_return got gnt/drvd/ifrvd %b rdata %h exp 010 00000055",
               {o_if_gnt, o_d_rvd, o_if_rvd}, o_d_rdata);
    end
    $display("txn data read addr=200 rdata=%h", o_d_rdata);
    next_cycle();
    i_mem_rvd = 1'b0;
    #1;
    vectors++;
    if ({o_if_gnt, o_mem_re, o_mem_addr} !== {2'b11, 32'h40}) begin
      miscompares++;
      $display("FAIL fetch_after_dread got %b addr %h exp 11 addr 00000040",
               {o_if_gnt, o_mem_re}, o_mem_addr);
    end
    next_cycle();
    i_if_req = 1'b0;
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h66;
    next_cycle();
    i_mem_rvd = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset_mid_read;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h400;
    next_cycle();
    i_d_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    i_mem_rvd = 1'b1; i_mem_rdata = 32'hAA;
    #1;
    vectors++;
    if ({o_d_rvd, o_if_rvd, o_busy, o_d_gnt, o_if_gnt, o_mem_we, o_mem_re} !== 7'b0) begin
      miscompares++;
      $display("FAIL rst_mid_read_strobes got %b exp 0000000",
               {o_d_rvd, o_if_rvd, o_busy, o_d_gnt, o_if_gnt, o_mem_we, o_mem_re});
    end
    vectors++;
    if ({o_d_rdata, o_if_rdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_mid_read_rdata got %h/%h exp 0/0", o_d_rdata, o_if_rdata);
    end
    $display("txn reset mid-read, late rvd ignored");
    next_cycle();
    i_mem_rvd = 1'b0;
    next_cycle();
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout;
    // give d_rdata a nonzero history so the forced zero is visible
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h500;
    next_cycle();
    i_d_req = 1'b0;
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h99;
    next_cycle();
    i_mem_rvd = 1'b0;
    next_cycle();
    i_d_req = 1'b1;
    next_cycle();
    i_d_req = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      #1;
      vectors++;
      if ({o_timeout, o_d_rvd, o_busy} !== 3'b001) begin
        miscompares++;
        $display("FAIL tmo_wait_c%0d got %b exp 001", c, {o_timeout, o_d_rvd, o_busy});
      end
      next_cycle();
    end
    #1;
    vectors++;
    if ({o_timeout, o_d_rvd, o_if_rvd, o_d_rdata} !== {3'b110, 32'h0}) begin
      miscompares++;
      $display("FAIL tmo_fire got tmo/drvd/ifrvd %b rdata %h exp 110 00000000",
               {o_timeout, o_d_rvd, o_if_rvd}, o_d_rdata);
    end
    $display("txn data read timeout rdata=%h", o_d_rdata);
    next_cycle();
    #1;
    vectors++;
    if ({o_busy, o_timeout} !== 2'b00) begin
      miscompares++;
      $display("FAIL tmo_idle got %b exp 00", {o_busy, o_timeout});
    end
    i_d_req = 1'b1;
    next_cycle();
    i_d_req = 1'b0;
    for (int c = 1; c <= 7; c++) next_cycle();
    i_mem_rvd = 1'b1; i_mem_rdata = 32'h77;
    #1;
    vectors++;
    if ({o_timeout, o_d_rvd, o_d_rdata} !== {2'b01, 32'h77}) begin
      miscompares++;
      $display("FAIL tmo_rvd_wins got tmo/drvd %b rdata %h exp 01 00000077",
               {o_timeout, o_d_rvd}, o_d_rdata);
    end
    $display("txn data read rvd on timeout cycle rdata=%h", o_d_rdata);
    next_cycle();
    i_mem_rvd = 1'b0;
    next_cycle();
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    i_if_req = 1'b0; i_if_addr = '0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0;
    i_mem_rdata = '0; i_mem_rvd = 1'b0;
    test_reset();
    test_write();
    test_fetch_read();
    test_starvation();
    test_read_blocks_fetch();
    test_reset_mid_read();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
